// File: rtl/audio_sample_queue.sv
// rtl/audio_sample_queue.sv - stereo sample history buffer streaming the last NUM_TAPS pairs to the band filters
module audio_sample_queue #(
    parameter int DEPTH    = 1024,
    parameter int NUM_TAPS = 1021,
    parameter int ADDR_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrt_smpl,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rght_smpl,
    output logic               sequencing,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out,
    output logic               seq_ovr
);

    localparam int FILL_W = $clog2(NUM_TAPS + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NUM_TAPS);
    localparam logic [FILL_W-1:0] FILL_TRIG = FILL_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] TAPS_MOD  = ADDR_W'(NUM_TAPS);
    localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_READ  = 2'd2,
        S_LAST  = 2'd3
    } state_t;

    logic signed [15:0] r_mem_l [0:DEPTH-1];
    logic signed [15:0] r_mem_r [0:DEPTH-1];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_new_ptr;
    logic [FILL_W-1:0]  r_fill_cnt;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_k;
    logic               r_sequencing;
    logic               r_seq_ovr;
    logic signed [15:0] r_lft_out;
    logic signed [15:0] r_rght_out;

    logic               w_trig_qual;
    logic               w_rd_en;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [ADDR_W-1:0]  w_base_nxt;

    // A write qualifies as a trigger once it completes a full window of NUM_TAPS samples
    assign w_trig_qual = wrt_smpl && (r_fill_cnt >= FILL_TRIG);
    // Oldest sample of the window ending at the sample being written now; wraps mod DEPTH
    assign w_base_nxt  = r_new_ptr + ADDR_W'(1) - TAPS_MOD;
    assign w_rd_addr   = r_base + r_k;

    // Sample storage: writes are accepted unconditionally, read-first on address clash
    always_ff @(posedge clk) begin
        if (wrt_smpl) begin
            r_mem_l[r_new_ptr] <= lft_smpl;
            r_mem_r[r_new_ptr] <= rght_smpl;
        end
    end

    // Write pointer and saturating fill count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_ptr  <= '0;
            r_fill_cnt <= '0;
        end else if (wrt_smpl) begin
            r_new_ptr <= r_new_ptr + ADDR_W'(1);
            if (r_fill_cnt != FILL_MAX) begin
                r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state: clear cycle, NUM_TAPS read cycles, final output cycle
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig_qual) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_READ;
            end
            S_READ: begin
                w_rd_en = 1'b1;
                if (r_k == K_LAST) begin
                    w_state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Window base latch and read offset counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
            r_k    <= '0;
        end else begin
            if (r_state == S_IDLE && w_trig_qual) begin
                r_base <= w_base_nxt;
            end
            if (r_state == S_START) begin
                r_k <= '0;
            end else if (r_state == S_READ) begin
                r_k <= r_k + ADDR_W'(1);
            end
        end
    end

    // Registered sequencing strobe and dropped-trigger pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sequencing <= 1'b0;
            r_seq_ovr    <= 1'b0;
        end else begin
            r_sequencing <= (w_state_nxt != S_IDLE);
            r_seq_ovr    <= w_trig_qual && (r_state != S_IDLE);
        end
    end

    // Registered RAM read data; holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_out  <= '0;
            r_rght_out <= '0;
        end else if (w_rd_en) begin
            r_lft_out  <= r_mem_l[w_rd_addr];
            r_rght_out <= r_mem_r[w_rd_addr];
        end
    end

    assign sequencing = r_sequencing;
    assign seq_ovr    = r_seq_ovr;
    assign lft_out    = r_lft_out;
    assign rght_out   = r_rght_out;

endmodule

// File: tb/tb_audio_sample_queue.sv
// tb/tb_audio_sample_queue.sv - self-checking bench for audio_sample_queue against a window-rule model
module tb_audio_sample_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_s, wrt_s, seq_s, ovr_s;
    logic signed [15:0] l_s, r_s, lo_s, ro_s;
    logic               rst_b, wrt_b, seq_b, ovr_b;
    logic signed [15:0] l_b, r_b, lo_b, ro_b;

    audio_sample_queue #(.DEPTH(8), .NUM_TAPS(4), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_s), .wrt_smpl(wrt_s), .lft_smpl(l_s), .rght_smpl(r_s),
        .sequencing(seq_s), .lft_out(lo_s), .rght_out(ro_s), .seq_ovr(ovr_s)
    );

    audio_sample_queue dut_big (
        .clk(clk), .rst_n(rst_b), .wrt_smpl(wrt_b), .lft_smpl(l_b), .rght_smpl(r_b),
        .sequencing(seq_b), .lft_out(lo_b), .rght_out(ro_b), .seq_ovr(ovr_b)
    );

    bit   big;
    logic seq_o, ovr_o;
    logic [15:0] lo_o, ro_o;
    assign seq_o = big ? seq_b : seq_s;
    assign ovr_o = big ? ovr_b : ovr_s;
    assign lo_o  = big ? lo_b  : lo_s;
    assign ro_o  = big ? ro_b  : ro_s;

    int n_cmp = 0;
    int n_err = 0;

    // Model: every sample since reset, and the window of the most recent trigger
    int          n_taps;
    int          cyc;
    int          nwr;
    int          t_start;
    int          seq_cnt_b;
    logic [15:0] hist_l[$], hist_r[$];
    logic [15:0] win_l[$],  win_r[$];
    logic [15:0] last_l, last_r;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit in_win(input int c);
        return (c >= t_start) && (c <= t_start + n_taps + 1);
    endfunction

    task automatic model_reset();
        nwr     = 0;
        t_start = -100000;
        last_l  = '0;
        last_r  = '0;
        hist_l.delete();
        hist_r.delete();
        win_l.delete();
        win_r.delete();
    endtask

    task automatic check_cycle(input bit ovr_exp);
        if (cyc >= t_start + 2 && cyc <= t_start + n_taps + 1) begin
            last_l = win_l[cyc - t_start - 2];
            last_r = win_r[cyc - t_start - 2];
        end
        if (big && seq_o) seq_cnt_b++;
        check_eq("sequencing", 16'(seq_o), 16'(in_win(cyc)));
        check_eq("lft_out", lo_o, last_l);
        check_eq("rght_out", ro_o, last_r);
        check_eq("seq_ovr", 16'(ovr_o), 16'(ovr_exp));
    endtask

    task automatic tick(input bit w, input logic [15:0] l, input logic [15:0] r);
        bit ovr_nxt;
        ovr_nxt = 1'b0;
        if (big) begin
            wrt_b = w; l_b = l; r_b = r;
        end else begin
            wrt_s = w; l_s = l; r_s = r;
        end
        if (w) begin
            hist_l.push_back(l);
            hist_r.push_back(r);
            if (nwr >= n_taps - 1) begin
                if (in_win(cyc)) begin
                    ovr_nxt = 1'b1;
                end else begin
                    t_start = cyc + 1;
                    win_l.delete();
                    win_r.delete();
                    for (int i = hist_l.size() - n_taps; i < hist_l.size(); i++) begin
                        win_l.push_back(hist_l[i]);
                        win_r.push_back(hist_r[i]);
                    end
                end
            end
            nwr++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        wrt_s = 1'b0;
        wrt_b = 1'b0;
        check_cycle(ovr_nxt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 16'h0);
    endtask

    task automatic wr(input int v);
        tick(1'b1, 16'(v), 16'(-v));
    endtask

    task automatic do_reset();
        if (big) rst_b = 1'b0; else rst_s = 1'b0;
        #1;
        check_eq("rst_sequencing", 16'(seq_o), 16'h0);
        check_eq("rst_lft_out", lo_o, 16'h0);
        check_eq("rst_rght_out", ro_o, 16'h0);
        check_eq("rst_seq_ovr", 16'(ovr_o), 16'h0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (big) rst_b = 1'b1; else rst_s = 1'b1;
    endtask

    initial begin
        big = 1'b0;
        rst_s = 1'b0; wrt_s = 1'b0; l_s = '0; r_s = '0;
        rst_b = 1'b0; wrt_b = 1'b0; l_b = '0; r_b = '0;
        cyc = 0;
        seq_cnt_b = 0;
        n_taps = 4;
        model_reset();
        @(negedge clk);
        do_reset();

        // Fill below threshold, then the completing write
        for (int v = 1; v <= 3; v++) begin
            wr(v);
            idle(1);
        end
        wr(4);
        idle(7);

        // Pointer wrap: widely spaced writes
        for (int v = 5; v <= 12; v++) begin
            wr(v);
            idle(8);
        end

        // Trigger dropped while busy, then picked up by the next trigger
        wr(13);
        idle(1);
        wr(14);
        idle(8);
        wr(15);
        idle(8);

        // Reset while reading k=2
        wr(16);
        idle(3);
        do_reset();
        for (int v = 21; v <= 23; v++) begin
            wr(v);
            idle(8);
        end
        wr(24);
        idle(8);

        // Randomized writes and values, including writes inside sequences
        for (int i = 0; i < 500; i++) begin
            tick(($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom));
        end
        idle(8);

        // Default parameters: full-length ramp
        big = 1'b1;
        n_taps = 1021;
        do_reset();
        for (int n = 1; n <= 1021; n++) wr(n);
        idle(1030);
        check_eq("big_seq_len", 16'(seq_cnt_b), 16'(1023));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
